// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: valid/ready nibble stream bundle for nibble_serial_subtractor
interface nibble_serial_subtractor_if;
    logic       in_valid, in_ready, bin, out_valid, out_ready, out_last, bout, ovf, zero;
    logic [3:0] a, b, diff;
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, out_last, bout, ovf, zero
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, out_last, bout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: A-B-bin streamed LSB nibble first through a 4-bit borrow-lookahead slice
module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input logic clk,
    input logic rst,
    nibble_serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
    logic          acc, ret, first, last, bi, zacc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          brw_q, zacc_q, vld_q, last_q, bout_q, ovf_q, zero_q;
    logic [3:0]    diff_q, g, p, d;
    logic [4:1]    x;
    assign acc   = bus.in_valid & bus.in_ready;
    assign ret   = vld_q & bus.out_ready;
    assign first = cnt_q == '0;
    assign last  = cnt_q == LAST;
    assign bi    = first ? bus.bin : brw_q;
    assign g     = ~bus.a & bus.b;
    assign p     = ~(bus.a ^ bus.b);
    // Flattened lookahead: every borrow comes straight from g/p and bi, no ripple
    assign x[1]  = g[0] | (p[0] & bi);
    assign x[2]  = g[1] | (p[1] & g[0]) | (&p[1:0] & bi);
    assign x[3]  = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & bi);
    assign x[4]  = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p & bi);
    assign d      = bus.a ^ bus.b ^ {x[3:1], bi};
    assign zacc_d = (first | zacc_q) & (d == 4'd0);
    assign cnt_d  = last ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            zacc_q <= 1'b1;
            vld_q  <= 1'b0;
            diff_q <= 4'd0;
            last_q <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            vld_q <= acc | (vld_q & ~ret);
            if (acc) begin
                cnt_q  <= cnt_d;
                brw_q  <= x[4];
                zacc_q <= zacc_d;
                diff_q <= d;
                last_q <= last;
                bout_q <= last & x[4];
                ovf_q  <= last & (x[4] ^ x[3]);
                zero_q <= last & zacc_d;
            end
        end
    end
    assign bus.in_ready  = ~vld_q | bus.out_ready;
    assign bus.out_valid = vld_q;
    assign bus.diff      = diff_q;
    assign bus.out_last  = last_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: scoreboard bench, whole-word arithmetic model vs nibble stream
module tb_nibble_serial_subtractor;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;
    typedef struct packed {
        logic [3:0] d;
        logic       last, bout, ovf, zero;
    } beat_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         vectors = 0;
    int         miscompares = 0;
    bit         bp_en = 1'b0;
    bit         gap_en = 1'b0;
    beat_t      sb[$];
    beat_t      e;
    logic       hold_prev = 1'b0;
    logic [3:0] hold_diff = 4'd0;
    logic       hold_last = 1'b0;
    nibble_serial_subtractor_if bus();
    nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic push_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        longint     r, sr;
        logic [W-1:0] dw;
        logic       ov;
        r  = longint'(a) - longint'(b) - longint'(bi);
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        dw = r[W-1:0];
        ov = (sr < -(64'sd1 <<< (W - 1))) || (sr > (64'sd1 <<< (W - 1)) - 1);
        for (int k = 0; k < NIBBLES; k++) begin
            logic lk;
            lk = (k == NIBBLES - 1);
            sb.push_back(beat_t'{d: dw[4*k+:4], last: lk, bout: lk & (r < 0),
                                 ovf: lk & ov, zero: lk & (dw == '0)});
        end
    endtask
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input int n);
        push_model(a, b, bi);
        for (int k = 0; k < n; k++) begin
            bit got;
            int tries;
            got = 1'b0;
            tries = 0;
            if (gap_en && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.a = a[4*k+:4];
            bus.b = b[4*k+:4];
            bus.bin = (k == 0) ? bi : 1'($urandom_range(0, 1));
            while (!got && tries < 100) begin
                @(negedge clk);
                got = bus.in_ready;
                tries++;
                @(posedge clk); #1;
            end
            if (!got) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", k, tries);
                return;
            end
            chk("out_valid_after_accept", {15'd0, bus.out_valid}, 16'd1);
        end
    endtask
    task automatic drain();
        int t;
        t = 0;
        bus.in_valid = 1'b0;
        bp_en = 1'b0;
        gap_en = 1'b0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask
    always begin
        @(posedge clk); #1;
        bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    always @(negedge clk) begin
        if (rst) hold_prev = 1'b0;
        else begin
            if (hold_prev) begin
                chk("hold_valid", {15'd0, bus.out_valid}, 16'd1);
                chk("hold_diff", {12'd0, bus.diff}, {12'd0, hold_diff});
                chk("hold_last", {15'd0, bus.out_last}, {15'd0, hold_last});
            end
            if (bus.out_valid && !bus.out_ready) chk("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_beat: got diff %0h with no beat expected", bus.diff);
                end else begin
                    e = sb.pop_front();
                    chk("diff", {12'd0, bus.diff}, {12'd0, e.d});
                    chk("out_last", {15'd0, bus.out_last}, {15'd0, e.last});
                    chk("bout", {15'd0, bus.bout}, {15'd0, e.bout});
                    chk("ovf", {15'd0, bus.ovf}, {15'd0, e.ovf});
                    chk("zero", {15'd0, bus.zero}, {15'd0, e.zero});
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_diff = bus.diff;
            hold_last = bus.out_last;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.a = 4'd0;
        bus.b = 4'd0;
        bus.bin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_diff", {12'd0, bus.diff}, 16'd0);
        chk("rst_out_last", {15'd0, bus.out_last}, 16'd0);
        chk("rst_bout", {15'd0, bus.bout}, 16'd0);
        chk("rst_ovf", {15'd0, bus.ovf}, 16'd0);
        chk("rst_zero", {15'd0, bus.zero}, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'h1234, 16'h0235, 1'b0, NIBBLES);
        run_op(16'h0000, 16'h0001, 1'b0, NIBBLES);
        run_op(16'h8000, 16'h0001, 1'b0, NIBBLES);
        run_op(16'h0005, 16'h0003, 1'b1, NIBBLES);
        run_op(16'hABCD, 16'hABCD, 1'b0, NIBBLES);
        run_op(16'hABCD, 16'hABCD, 1'b1, NIBBLES);
        drain();
        bp_en = 1'b1;
        gap_en = 1'b1;
        repeat (3) run_op(16'h1234, 16'h0235, 1'b0, NIBBLES);
        repeat (20) run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), NIBBLES);
        drain();
        run_op(16'h1234, 16'h0235, 1'b0, 2);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {15'd0, bus.out_valid}, 16'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(16'h0000, 16'h0001, 1'b0, NIBBLES);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Bit-sliced, multi-cycle subtractor that computes A − B − bin on operands of NIBBLES×4 bits, streamed in one nibble per cycle, least-significant nibble first. Each nibble is resolved by a 4-bit borrow-lookahead slice. The borrow is carried between beats in a register. This block is the subtract counterpart of the team's 4-bit carry-lookahead adder and serves arithmetic datapaths that need wide differences without a wide combinational borrow chain. Both sides of the stream use valid/ready handshakes, and there is one output register stage.

## Interface
- NIBBLES, default 4: operand length in nibbles (total width 4×NIBBLES). Legal range 2..16.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  a/b nibble (and bin on the first beat) is present
- in_ready  out  1  block accepts the input beat this cycle
- a  in  4  minuend nibble
- b  in  4  subtrahend nibble
- bin  in  1  borrow-in; sampled only on the first beat of an operation
- out_valid  out  1  diff nibble is valid
- out_ready  in  1  consumer accepts the output beat
- diff  out  4  difference nibble
- out_last  out  1  the current output beat is the most-significant nibble
- bout  out  1  final borrow-out (unsigned underflow); meaningful only when out_last=1, otherwise 0
- ovf  out  1  signed overflow; meaningful only when out_last=1, otherwise 0
- zero  out  1  the entire 4×NIBBLES-bit difference is zero; meaningful only when out_last=1, otherwise 0

## Operation
- Input accept: `acc = in_valid & in_ready`. Output accept: `ret = out_valid & out_ready`.
- Beat counter `cnt`:
  - width clog2(NIBBLES), range 0..NIBBLES-1.
  - Increments on acc and wraps to 0 after NIBBLES-1.
  - cnt==0 marks the first beat; cnt==NIBBLES-1 marks the last beat.
- Borrow source `bi`: `bi = (cnt==0) ? bin : brw_q`, where brw_q is the borrow register.
- Slice logic, for i = 0..3, with x[0] = bi:
  - generate `g[i] = ~a[i] & b[i]`
  - propagate `p[i] = ~(a[i] ^ b[i])`
  - borrow chain `x[i+1] = g[i] | (p[i] & x[i])`
  - difference `d[i] = a[i] ^ b[i] ^ x[i]`
- Register updates on acc:
  - brw_q <= x[4]
  - zacc <= ((cnt==0) ? 1 : zacc) & (d==0)
  - diff <= d
  - out_last <= (cnt==NIBBLES-1)
- Last-beat flags, registered with that beat:
  - bout <= x[4]
  - ovf <= x[4] ^ x[3]
  - zero <= zacc_next
  - On non-last beats, bout, ovf and zero load 0.
- out_valid:
  - Set on acc.
  - Cleared on a ret cycle that has no acc.
  - Stays 1 when acc and ret occur in the same cycle.
- in_ready = !out_valid | out_ready. This is a combinational path from out_ready; no other combinational in→out paths exist.
- There is no abort. A new operation begins on the beat following a last beat.

## Timing
- Reset values of all outputs and state: out_valid=0, diff=0, out_last=0, bout=0, ovf=0, zero=0, cnt=0, brw_q=0, zacc=1. in_ready=1 while in reset.
- Latency: a beat accepted on edge k appears on the outputs after edge k, so out_valid=1 in cycle k+1.
- Throughput: one nibble per cycle while out_ready=1. A full operation takes NIBBLES cycles plus 1 cycle of latency.
- Back-pressure:
  - While out_valid=1 and out_ready=0, in_ready=0.
  - All outputs hold stable.
  - cnt and brw_q do not change.
- Bubbles: an in_valid=0 cycle between beats does not disturb cnt or brw_q. The operation resumes on the next accepted beat.
- Wrap-around: after the last beat, cnt returns to 0. The next beat samples bin, not brw_q.
- Reset mid-operation: the partial result is discarded, cnt returns to 0, and out_valid drops immediately (asynchronously). The first beat after reset release is treated as nibble 0.

## Test plan
- NIBBLES=4, bin=0, 0x1234−0x0235, nibbles LSB first, out_ready=1:
  - diff beats F, F, F, 0 (the word reads 0x0FFF)
  - out_last set on beat 4 only
  - bout=0, ovf=0, zero=0
  - out_valid high for 4 consecutive cycles, starting 1 cycle after the first accept.
- 0x0000−0x0001, bin=0 → diff 0xFFFF, bout=1, ovf=0, zero=0.
- 0x8000−0x0001 → diff 0x7FFF, bout=0, ovf=1. Then 0x0005−0x0003 with bin=1 → diff 0x0001, bout=0. The second operation checks that bin is re-sampled after the wrap.
- 0xABCD−0xABCD, bin=0 → all diff nibbles 0, zero=1 on the last beat, bout=0. Repeat with bin=1 → diff 0xFFFF, zero=0, bout=1.
- Back-pressure and bubbles on 0x1234−0x0235:
  - Toggle out_ready pseudo-randomly and insert in_valid=0 gaps.
  - Results must match the first scenario.
  - While out_valid=1 and out_ready=0: in_ready=0 and diff is stable.
  - No beats are lost or duplicated.
- Reset mid-operation:
  - Assert rst after 2 of 4 beats → out_valid=0 immediately.
  - After release, a fresh 0x0000−0x0001 → diff 0xFFFF, bout=1. This shows no stale borrow and no stale count survived the reset.
